// File: rtl/instruction_fetch_if.sv
// Bundles the instruction-memory request/ack bus and the decoder-facing fetch signals.
// master is the fetch unit; slave is the memory/decoder side.
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic        instr_valid;
    logic        instr_ready;
    logic        branch;
    logic        jump;
    logic        jr;
    logic        jal;
    logic        alu_zero;
    logic [31:0] jr_target;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic [31:0] retire_count;

    modport master (
        output imem_req, imem_addr, instruction, instr_valid, pc, link_addr, retire_count,
        input  imem_ack, imem_rdata, instr_ready, branch, jump, jr, jal, alu_zero, jr_target
    );

    modport slave (
        input  imem_req, imem_addr, instruction, instr_valid, pc, link_addr, retire_count,
        output imem_ack, imem_rdata, instr_ready, branch, jump, jr, jal, alu_zero, jr_target
    );
endinterface

// File: rtl/instruction_fetch.sv
// Single-outstanding-request instruction fetch unit: fetches the word at pc, holds it
// for the decoder until retired, then redirects pc via JR / J / BNE / sequential flow.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic                  clk,
    input logic                  rst_n,
    instruction_fetch_if.master  bus
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_instruction;
    logic        r_instr_valid;
    logic [31:0] r_retire_count;

    logic        w_imem_req;
    logic        w_load;
    logic        w_retire;
    logic [31:0] w_link_addr;
    logic [31:0] w_branch_offset;
    logic [31:0] w_next_pc;
    logic        w_unused;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_imem_req   = 1'b0;
        w_load       = 1'b0;
        w_retire     = 1'b0;
        case (r_state)
            IDLE: begin
                w_next_state = REQ;
            end
            REQ: begin
                w_imem_req = 1'b1;
                if (bus.imem_ack) begin
                    w_load       = 1'b1;
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    w_retire     = 1'b1;
                    w_next_state = REQ;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_link_addr     = r_pc + 32'd4;
    assign w_branch_offset = {{14{r_instruction[15]}}, r_instruction[15:0], 2'b00};

    // Only sampled when w_retire is set, so the control inputs are don't-care elsewhere.
    always_comb begin
        if (bus.jr) begin
            w_next_pc = {bus.jr_target[31:2], 2'b00};
        end else if (bus.jump) begin
            w_next_pc = {w_link_addr[31:28], r_instruction[25:0], 2'b00};
        end else if (bus.branch && !bus.alu_zero) begin
            w_next_pc = w_link_addr + w_branch_offset;
        end else begin
            w_next_pc = w_link_addr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc           <= RESET_PC;
            r_instruction  <= 32'd0;
            r_instr_valid  <= 1'b0;
            r_retire_count <= 32'd0;
        end else begin
            if (w_load) begin
                r_instruction <= bus.imem_rdata;
                r_instr_valid <= 1'b1;
            end
            if (w_retire) begin
                r_pc           <= w_next_pc;
                r_instr_valid  <= 1'b0;
                r_retire_count <= r_retire_count + 32'd1;
            end
        end
    end

    // jal only selects link_addr as write data downstream; the target itself follows jump.
    assign w_unused = ^{bus.jal, bus.jr_target[1:0]};

    assign bus.imem_req     = w_imem_req;
    assign bus.imem_addr    = r_pc;
    assign bus.instruction  = r_instruction;
    assign bus.instr_valid  = r_instr_valid;
    assign bus.pc           = r_pc;
    assign bus.link_addr    = w_link_addr;
    assign bus.retire_count = r_retire_count;

endmodule
